// File: rtl/if_id_pipe_pkg.sv
// Shared widths, the NOP encoding and the stage state type for the IF/ID pipeline register.
package if_id_pkg;

    localparam int          PC_W_DEF     = 32;
    localparam int          INST_W_DEF   = 32;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
    localparam int          CNT_W        = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

endpackage

// File: rtl/if_id_pipe_if.sv
// Fetch-to-decode handshake bundle; the stage is the slave, fetch/decode/hazard logic the master.
interface if_id_pipe_if #(
    parameter int PC_W   = 32,
    parameter int INST_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [PC_W-1:0]   pc_plus_in;
    logic [INST_W-1:0] inst_in;
    logic              out_valid;
    logic              out_ready;
    logic [PC_W-1:0]   pc_plus_out;
    logic [INST_W-1:0] inst_out;
    logic              stall;
    logic              flush;

    modport slave (
        input  in_valid, pc_plus_in, inst_in, out_ready, stall, flush,
        output in_ready, out_valid, pc_plus_out, inst_out
    );

    modport master (
        output in_valid, pc_plus_in, inst_in, out_ready, stall, flush,
        input  in_ready, out_valid, pc_plus_out, inst_out
    );
endinterface

// File: rtl/if_id_pipe_sat_cnt.sv
// Saturating up-counter (sat_cnt): holds at all-ones instead of wrapping; clear wins over inc.
module sat_cnt #(
    parameter int           W         = 32,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= RESET_VAL;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != '1)) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/if_id_pipe.sv
// IF/ID pipeline register with a one-entry skid buffer, stall hold and flush squash.
// Optional perf counters are built when IF_ID_PIPE_PERF_CNT_EN is defined.
//
//  state | meaning
//  EMPTY | nothing held, inst_out = NOP, in_ready = 1
//  ONE   | main entry valid, skid empty, in_ready = 1
//  TWO   | main and skid valid, in_ready = 0
module if_id_pipe
    import if_id_pkg::*;
#(
    parameter int                PC_W     = PC_W_DEF,
    parameter int                INST_W   = INST_W_DEF,
    parameter logic [INST_W-1:0] NOP_INST = NOP_INST_DEF
) (
    input  logic             clk,
    input  logic             rst,
    if_id_pipe_if.slave      bus
`ifdef IF_ID_PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] bubble_cnt
`endif
);

    state_e            state;
    logic [PC_W-1:0]   main_pc;
    logic [INST_W-1:0] main_inst;
    logic [PC_W-1:0]   skid_pc;
    logic [INST_W-1:0] skid_inst;
    logic              in_ready_q;
    logic              main_valid;
    logic              acc_fire;
    logic              rel_fire;

    assign main_valid      = (state != EMPTY);
    assign bus.out_valid   = main_valid & ~bus.stall;
    assign bus.in_ready    = in_ready_q;
    assign bus.pc_plus_out = main_pc;
    assign bus.inst_out    = main_inst;

    assign acc_fire = bus.in_valid & in_ready_q & ~bus.flush;
    assign rel_fire = bus.out_valid & bus.out_ready;

    // main_inst is forced to NOP whenever the stage drains or is squashed,
    // so inst_out needs no output mux; pc_plus_out deliberately keeps its value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= EMPTY;
            main_pc    <= '0;
            main_inst  <= NOP_INST;
            skid_pc    <= '0;
            skid_inst  <= NOP_INST;
            in_ready_q <= 1'b1;
        end else if (bus.flush) begin
            state      <= EMPTY;
            main_inst  <= NOP_INST;
            in_ready_q <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (acc_fire) begin
                        main_pc   <= bus.pc_plus_in;
                        main_inst <= bus.inst_in;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (acc_fire && rel_fire) begin
                        main_pc   <= bus.pc_plus_in;
                        main_inst <= bus.inst_in;
                    end else if (acc_fire) begin
                        skid_pc    <= bus.pc_plus_in;
                        skid_inst  <= bus.inst_in;
                        in_ready_q <= 1'b0;
                        state      <= TWO;
                    end else if (rel_fire) begin
                        main_inst <= NOP_INST;
                        state     <= EMPTY;
                    end
                end
                TWO: begin
                    if (rel_fire) begin
                        main_pc    <= skid_pc;
                        main_inst  <= skid_inst;
                        in_ready_q <= 1'b1;
                        state      <= ONE;
                    end
                end
                default: begin
                    main_inst  <= NOP_INST;
                    in_ready_q <= 1'b1;
                    state      <= EMPTY;
                end
            endcase
        end
    end

`ifdef IF_ID_PIPE_PERF_CNT_EN
    sat_cnt #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (bus.stall),
        .cnt   (stall_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (bus.flush),
        .cnt   (flush_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (1'b0),
        .inc   (~bus.out_valid & bus.out_ready),
        .cnt   (bubble_cnt)
    );
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Directed-vector bench for if_id_pipe and sat_cnt; perf counters checked when IF_ID_PIPE_PERF_CNT_EN is set.
module tb_if_id_pipe;
    import if_id_pkg::*;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    if_id_pipe_if #(.PC_W(32), .INST_W(32)) bus ();

`ifdef IF_ID_PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic [31:0] bubble_cnt;
`endif

    if_id_pipe dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef IF_ID_PIPE_PERF_CNT_EN
        ,
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .bubble_cnt (bubble_cnt)
`endif
    );

    logic        sat_inc;
    logic        sat_clr;
    logic [31:0] sat_val;

    sat_cnt #(.W(32), .RESET_VAL(32'hFFFF_FFFF)) u_sat (
        .clk   (clk),
        .rst   (rst),
        .clear (sat_clr),
        .inc   (sat_inc),
        .cnt   (sat_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc);
        bus.in_valid   = 1'b1;
        bus.pc_plus_in = pc;
        bus.inst_in    = 32'h1000_0000 | pc;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
        chk("rst_pc",        64'(bus.pc_plus_out), 64'd0);
        chk("rst_inst",      64'(bus.inst_out),  64'd0);
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        bus.in_valid   = 1'b0;
        bus.pc_plus_in = '0;
        bus.inst_in    = '0;
        bus.out_ready  = 1'b0;
        bus.stall      = 1'b0;
        bus.flush      = 1'b0;
        sat_inc        = 1'b0;
        sat_clr        = 1'b0;
        rst            = 1'b0;
        #1;
        pulse_reset();
        tick();

        // single pass-through, latency 1
        bus.in_valid   = 1'b1;
        bus.pc_plus_in = 32'h4;
        bus.inst_in    = 32'h2002_0005;
        bus.out_ready  = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        chk("t1_out_valid", 64'(bus.out_valid),   64'd1);
        chk("t1_pc",        64'(bus.pc_plus_out), 64'h4);
        chk("t1_inst",      64'(bus.inst_out),    64'h2002_0005);
        chk("t1_in_ready",  64'(bus.in_ready),    64'd1);
        tick();
        chk("t1_drain_valid", 64'(bus.out_valid), 64'd0);
        chk("t1_drain_inst",  64'(bus.inst_out),  64'd0);

        // back-to-back offers into a blocked consumer, then ordered drain
        bus.out_ready = 1'b0;
        offer(32'h4);
        tick();
        offer(32'h8);
        tick();
        chk("t2_two_in_ready", 64'(bus.in_ready),    64'd0);
        chk("t2_two_pc",       64'(bus.pc_plus_out), 64'h4);
        offer(32'hC);
        tick();
        chk("t2_held_in_ready", 64'(bus.in_ready),    64'd0);
        chk("t2_held_pc",       64'(bus.pc_plus_out), 64'h4);
        chk("t2_held_inst",     64'(bus.inst_out),    64'h1000_0004);
        bus.out_ready = 1'b1;
        tick();
        chk("t2_second_pc",   64'(bus.pc_plus_out), 64'h8);
        chk("t2_second_inst", 64'(bus.inst_out),    64'h1000_0008);
        chk("t2_ready_again", 64'(bus.in_ready),    64'd1);
        tick();
        bus.in_valid = 1'b0;
        chk("t2_third_pc",    64'(bus.pc_plus_out), 64'hC);
        chk("t2_third_valid", 64'(bus.out_valid),   64'd1);
        tick();
        chk("t2_empty_valid", 64'(bus.out_valid), 64'd0);

        // flush in TWO with a live offer
        bus.out_ready = 1'b0;
        offer(32'h10);
        tick();
        offer(32'h14);
        tick();
        offer(32'h18);
        bus.flush = 1'b1;
        tick();
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        chk("t3_flush_valid", 64'(bus.out_valid),   64'd0);
        chk("t3_flush_inst",  64'(bus.inst_out),    64'd0);
        chk("t3_flush_ready", 64'(bus.in_ready),    64'd1);
        chk("t3_flush_pc",    64'(bus.pc_plus_out), 64'h10);
        bus.out_ready = 1'b1;
        tick();
        chk("t3_no_capture", 64'(bus.out_valid), 64'd0);

        // stall and flush together in TWO: flush wins
        bus.out_ready = 1'b0;
        offer(32'h20);
        tick();
        offer(32'h24);
        tick();
        bus.in_valid  = 1'b0;
        bus.stall     = 1'b1;
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        chk("t4_sf_valid", 64'(bus.out_valid), 64'd0);
        chk("t4_sf_ready", 64'(bus.in_ready),  64'd1);
        tick();
        chk("t4_sf_stay_empty", 64'(bus.out_valid), 64'd0);

        // stall in ONE for three cycles with consumer ready
        bus.out_ready = 1'b0;
        offer(32'h30);
        tick();
        bus.in_valid  = 1'b0;
        bus.stall     = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        chk("t5_stall_valid", 64'(bus.out_valid), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t5_stall_hold_valid", 64'(bus.out_valid),   64'd0);
            chk("t5_stall_hold_pc",    64'(bus.pc_plus_out), 64'h30);
        end
        bus.stall = 1'b0;
        #1;
        chk("t5_release_valid", 64'(bus.out_valid),   64'd1);
        chk("t5_release_pc",    64'(bus.pc_plus_out), 64'h30);
        tick();
        chk("t5_delivered_once", 64'(bus.out_valid), 64'd0);

        // reset mid-transfer discards held entries
        bus.out_ready = 1'b0;
        offer(32'h40);
        tick();
        offer(32'h44);
        tick();
        bus.in_valid = 1'b0;
        pulse_reset();
        bus.out_ready = 1'b1;
        tick();
        chk("t6_no_replay", 64'(bus.out_valid), 64'd0);

`ifdef IF_ID_PIPE_PERF_CNT_EN
        pulse_reset();
        chk("pc_stall_clr", 64'(stall_cnt), 64'd0);
        chk("pc_flush_clr", 64'(flush_cnt), 64'd0);
        bus.stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        bus.stall = 1'b0;
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        chk("pc_stall_cnt", 64'(stall_cnt), 64'd5);
        chk("pc_flush_cnt", 64'(flush_cnt), 64'd1);
`endif

        // saturating counter preloaded at all-ones must not wrap
        sat_inc = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("sat_no_wrap", 64'(sat_val), 64'hFFFF_FFFF);
        sat_clr = 1'b1;
        tick();
        chk("sat_clear", 64'(sat_val), 64'd0);
        sat_clr = 1'b0;
        tick();
        chk("sat_inc", 64'(sat_val), 64'd1);
        sat_inc = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_pipe.md
IF_ID_PIPE -- requirements
Module: if_id_pipe

Interface
REQ-001 Parameter PC_W, default 32, width of the PC+4 payload.
REQ-002 Parameter INST_W, default 32, width of the instruction payload.
REQ-003 Parameter NOP_INST, default 32'h0000_0000, instruction value driven when the stage is empty or flushed.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  fetch offers a PC+4/instruction pair.
REQ-007 in_ready  output  1  stage accepts the offered pair this cycle.
REQ-008 pc_plus_in  input  PC_W  fetch PC+4.
REQ-009 inst_in  input  INST_W  fetched instruction.
REQ-010 out_valid  output  1  decode-side pair is valid.
REQ-011 out_ready  input  1  decode consumes the pair this cycle.
REQ-012 pc_plus_out  output  PC_W  registered PC+4.
REQ-013 inst_out  output  INST_W  registered instruction.
REQ-014 stall  input  1  hazard-unit hold; freezes the stage contents.
REQ-015 flush  input  1  branch/jump squash; discards all held entries.

Function
REQ-016 Storage: one main entry (drives outputs) plus one skid entry; states EMPTY, ONE, TWO.
REQ-017 in_ready = !skid_valid, registered only; no combinational path from out_ready/stall/flush to in_ready.
REQ-018 accept = in_valid & in_ready & !flush; release = out_valid & out_ready.
REQ-019 out_valid = main_valid & !stall; while stall is high, no release, contents and outputs hold.
REQ-020 EMPTY + accept -> ONE; input is written to main; visible on outputs the next cycle (latency 1).
REQ-021 ONE + accept + release -> ONE; main replaced by the input.
REQ-022 ONE + accept + !release -> TWO; input written to skid.
REQ-023 ONE + release + !accept -> EMPTY.
REQ-024 TWO + release -> ONE; skid moves to main. No accept is possible in TWO.
REQ-025 flush takes priority over accept, release and stall: next state EMPTY, inst_out = NOP_INST, pc_plus_out holds its value, in_ready = 1.
REQ-026 In EMPTY, inst_out = NOP_INST.
REQ-027 Entries leave in arrival order; no pair is duplicated or dropped except by flush.

Reset
REQ-028 While rst is high: state EMPTY, out_valid 0, pc_plus_out 0, inst_out NOP_INST, in_ready 1.
REQ-029 If rst asserts mid-transfer, all held entries are discarded; nothing is replayed after release.

Configuration
REQ-030 Macro IF_ID_PIPE_PERF_CNT_EN: when defined, 32-bit saturating output counters stall_cnt, flush_cnt and bubble_cnt are present. bubble_cnt counts cycles with out_valid = 0 and out_ready = 1. All three are cleared by rst.
REQ-031 Without IF_ID_PIPE_PERF_CNT_EN: the counters and their ports are absent; all other behaviour is identical.

Structure
REQ-032 Package if_id_pkg holds the default widths, the NOP_INST constant and the state enum {EMPTY, ONE, TWO}.
REQ-033 The counters use one sub-module, sat_cnt (parametrised width, inc, clear, saturating at all-ones), instantiated three times.

Verification
REQ-034 Reset release, in_valid=1, pc 0x4, inst 0x2002_0005, out_ready=1 -> next cycle out_valid=1 with those values; in_ready stays 1.
REQ-035 out_ready=0, three back-to-back offers 0x4, 0x8, 0xC -> 0x4 in main, 0x8 in skid, in_ready=0, 0xC held off; then out_ready=1 -> 0x4, 0x8, 0xC delivered in order.
REQ-036 State TWO, flush=1 with in_valid=1 -> next cycle out_valid=0, inst_out=0x0000_0000, in_ready=1, input not captured.
REQ-037 State ONE, stall=1 for 3 cycles with out_ready=1 -> out_valid=0, outputs frozen; pair delivered on the first cycle after stall drops.
REQ-038 stall and flush asserted together in TWO -> flush wins: EMPTY next cycle.
REQ-039 With IF_ID_PIPE_PERF_CNT_EN, stall held 5 cycles then one flush -> stall_cnt=5, flush_cnt=1; a counter preloaded at 0xFFFF_FFFF does not wrap.
